// File: rtl/mul_out_ser.sv
// mul_out_ser: buffers 96-bit multiplier products in a FIFO and serializes each as 12 bytes.
// Byte order is MSB-first by default; define MUL_OUT_SER_LSB_FIRST_EN for LSB-first.
module mul_out_ser #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [95:0]            in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);
  // state   | meaning
  // ST_IDLE | shifter empty, waiting for a word in the FIFO
  // ST_SEND | shifter holds a word, presenting byte r_byte_cnt
  localparam int          AW           = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL      = (AW+1)'(DEPTH);
  localparam logic [3:0]  LP_LAST_BYTE = 4'd11;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [95:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [95:0]   r_shift;
  logic [3:0]    r_byte_cnt;
  logic          r_ovf;
  logic          w_xfer;
  logic          w_last_xfer;
  logic          w_pop;
  logic          w_push;
  logic          w_fifo_empty;
  logic [7:0]    w_head_byte;

  assign w_fifo_empty = (r_level == '0);
  assign w_xfer       = (r_state == ST_SEND) && out_ready;
  assign w_last_xfer  = w_xfer && (r_byte_cnt == LP_LAST_BYTE);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last_xfer) begin
          if (!w_fifo_empty) w_pop = 1'b1;
          else               w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A full FIFO still takes a word when its head leaves on the same edge.
  assign w_push = in_valid && ((r_level != LP_FULL) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (in_valid && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (w_pop) begin
      r_shift    <= r_mem[r_rd_ptr];
      r_byte_cnt <= '0;
    end else if (w_xfer) begin
`ifdef MUL_OUT_SER_LSB_FIRST_EN
      r_shift    <= {8'h00, r_shift[95:8]};
`else
      r_shift    <= {r_shift[87:0], 8'h00};
`endif
      r_byte_cnt <= w_last_xfer ? 4'd0 : r_byte_cnt + 4'd1;
    end
  end

`ifdef MUL_OUT_SER_LSB_FIRST_EN
  assign w_head_byte = r_shift[7:0];
`else
  assign w_head_byte = r_shift[95:88];
`endif

  assign out_valid = (r_state == ST_SEND);
  assign out_data  = (r_state == ST_SEND) ? w_head_byte : 8'h00;
  assign out_last  = (r_state == ST_SEND) && (r_byte_cnt == LP_LAST_BYTE);
  assign level     = r_level;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mul_out_ser.sv
// Testbench for mul_out_ser: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mul_out_ser;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef MUL_OUT_SER_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [95:0]   in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_last;
  logic [LW-1:0] level;
  logic          ovf;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queued words, word being sent, index of the byte on the output.
  logic [95:0] m_fifo[$];
  logic [95:0] m_cur = '0;
  int          m_idx = 0;
  bit          m_busy = 1'b0;
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  mul_out_ser #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .level(level), .ovf(ovf)
  );

  function automatic logic [7:0] byte_of(input logic [95:0] w, input int k);
    if (LSB_FIRST) return w[8*k +: 8];
    else           return w[95-8*k -: 8];
  endfunction

  function automatic logic [95:0] rand_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_busy    = 1'b0;
    m_idx     = 0;
    m_ovf     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Drive one cycle, advance the model across the coming edge, sample 1ns after it.
  task automatic step(input bit vld, input logic [95:0] d, input bit rdy);
    bit xfer, fin, pop, acc;
    in_valid  = vld;
    in_data   = d;
    out_ready = rdy;
    xfer = m_busy && rdy;
    fin  = xfer && (m_idx == 11);
    pop  = (m_fifo.size() > 0) && (!m_busy || fin);
    acc  = vld && ((m_fifo.size() < DEPTH) || pop);
    if (pop) begin
      m_cur  = m_fifo.pop_front();
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (fin) m_busy = 1'b0;
    else if (xfer)    m_idx++;
    if (acc)      m_fifo.push_back(d);
    else if (vld) m_ovf = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = rand_word();
    #12;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || level !== '0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%0b data=%h last=%0b level=%0d ovf=%0b, need all 0",
               out_valid, out_data, out_last, level, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    step(1'b1, 96'h0102030405060708090A0B0C, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || level !== LW'(1)) begin
      n_err++;
      $display("FAIL sw_latency1: got valid=%0b level=%0d, need valid=0 level=1", out_valid, level);
    end
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      exp = LSB_FIRST ? 8'(12 - k) : 8'(k + 1);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp || out_last !== (k == 11)) begin
        n_err++;
        $display("FAIL sw_byte%0d: got valid=%0b data=%h last=%0b, need 1 %h %0b",
                 k, out_valid, out_data, out_last, exp, (k == 11));
      end
      step(1'b0, '0, 1'b1);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sw_idle: got valid=%0b, need 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int nx = 0;
    bit rdy, hold = 1'b0, done = 1'b0;
    logic [7:0] prev = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      rdy = (cyc % 2 == 0);
      if (hold) begin
        n_vec++;
        if (out_data !== prev || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL bp_stable: got valid=%0b data=%h, need 1 %h", out_valid, out_data, prev);
        end
      end
      if (m_busy) begin
        n_vec++;
        if (out_data !== byte_of(m_cur, m_idx) || out_last !== (m_idx == 11)) begin
          n_err++;
          $display("FAIL bp_byte: got %h last=%0b, need %h last=%0b",
                   out_data, out_last, byte_of(m_cur, m_idx), (m_idx == 11));
        end
      end
      if (out_valid && rdy) nx++;
      hold = out_valid && !rdy;
      prev = out_data;
      step(cyc == 0, rand_word(), rdy);
      done = (cyc > 0) && !m_busy && (m_fifo.size() == 0);
    end
    n_vec++;
    if (nx !== 12 || !done) begin
      n_err++;
      $display("FAIL bp_count: got %0d transfers done=%0b, need 12 done=1", nx, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [95:0] w [3];
    int nvalid = 0, peak = 0;
    bit gap = 1'b0, done = 1'b0;
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      step(cyc < 3, (cyc < 3) ? w[cyc % 3] : 96'h0, 1'b1);
      if (int'(level) > peak) peak = int'(level);
      if (out_valid) nvalid++;
      else if (nvalid > 0 && nvalid < 36) gap = 1'b1;
      n_vec++;
      if (out_valid !== m_busy || (m_busy && out_data !== byte_of(m_cur, m_idx))) begin
        n_err++;
        $display("FAIL b2b_byte: got valid=%0b data=%h, need %0b %h",
                 out_valid, out_data, m_busy, byte_of(m_cur, m_idx));
      end
      done = (cyc >= 3) && !m_busy;
    end
    n_vec++;
    if (nvalid !== 36 || gap || peak !== 2 || !done) begin
      n_err++;
      $display("FAIL b2b_summary: got bytes=%0d gap=%0b peak=%0d done=%0b, need 36 0 2 1",
               nvalid, gap, peak, done);
    end
  endtask

  task automatic test_overflow();
    int nx = 0;
    bit done = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, rand_word(), 1'b0);
    n_vec++;
    if (level !== LW'(4) || ovf !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: got level=%0d ovf=%0b valid=%0b, need 4 1 1", level, ovf, out_valid);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    n_vec++;
    if (ovf !== 1'b1 || out_data !== byte_of(m_cur, 0)) begin
      n_err++;
      $display("FAIL ovf_sticky: got ovf=%0b data=%h, need 1 %h", ovf, out_data, byte_of(m_cur, 0));
    end
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (m_busy) begin
        n_vec++;
        if (out_data !== byte_of(m_cur, m_idx) || level !== LW'(m_fifo.size())) begin
          n_err++;
          $display("FAIL ovf_drain: got data=%h level=%0d, need %h %0d",
                   out_data, level, byte_of(m_cur, m_idx), m_fifo.size());
        end
      end
      if (out_valid) nx++;
      step(1'b0, '0, 1'b1);
      done = !m_busy;
    end
    n_vec++;
    if (nx !== 60 || ovf !== 1'b1 || out_valid !== 1'b0 || !done) begin
      n_err++;
      $display("FAIL ovf_total: got bytes=%0d ovf=%0b valid=%0b, need 60 1 0", nx, ovf, out_valid);
    end
  endtask

  task automatic test_full_pop();
    int nx = 0;
    bit done = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, '0, 1'b1);
    n_vec++;
    if (out_last !== 1'b1 || level !== LW'(4)) begin
      n_err++;
      $display("FAIL fp_setup: got last=%0b level=%0d, need 1 4", out_last, level);
    end
    step(1'b1, rand_word(), 1'b1);
    n_vec++;
    if (level !== LW'(4) || ovf !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b0 ||
        out_data !== byte_of(m_cur, 0)) begin
      n_err++;
      $display("FAIL fp_accept: got level=%0d ovf=%0b valid=%0b last=%0b data=%h, need 4 0 1 0 %h",
               level, ovf, out_valid, out_last, out_data, byte_of(m_cur, 0));
    end
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (out_valid) nx++;
      step(1'b0, '0, 1'b1);
      n_vec++;
      if (out_valid !== m_busy || (m_busy && out_data !== byte_of(m_cur, m_idx))) begin
        n_err++;
        $display("FAIL fp_drain: got valid=%0b data=%h, need %0b %h",
                 out_valid, out_data, m_busy, byte_of(m_cur, m_idx));
      end
      done = !m_busy;
    end
    n_vec++;
    if (nx !== 60 || ovf !== 1'b0 || !done) begin
      n_err++;
      $display("FAIL fp_total: got bytes=%0d ovf=%0b, need 60 0", nx, ovf);
    end
  endtask

  task automatic test_reset_mid();
    int nff = 0, stale = 0;
    step(1'b1, rand_word(), 1'b1);
    step(1'b1, rand_word(), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    n_vec++;
    if (out_data !== byte_of(m_cur, 6) || level !== LW'(1)) begin
      n_err++;
      $display("FAIL rm_before: got data=%h level=%0d, need %h 1", out_data, level, byte_of(m_cur, 6));
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || level !== '0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL rm_async: got valid=%0b data=%h last=%0b level=%0d ovf=%0b, need all 0",
               out_valid, out_data, out_last, level, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 16; cyc++) begin
      step(cyc == 0, {96{1'b1}}, 1'b1);
      if (out_valid) begin
        if (out_data === 8'hFF) nff++;
        else                    stale++;
      end
    end
    n_vec++;
    if (nff !== 12 || stale !== 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rm_after: got ff_bytes=%0d other=%0d valid=%0b, need 12 0 0", nff, stale, out_valid);
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    for (int cyc = 0; cyc < 700 && !done; cyc++) begin
      if (cyc < 400) step($urandom_range(0, 7) == 0, rand_word(), $urandom_range(0, 3) != 0);
      else           step(1'b0, '0, 1'b1);
      n_vec++;
      if (out_valid !== m_busy || level !== LW'(m_fifo.size()) || ovf !== m_ovf ||
          (m_busy && (out_data !== byte_of(m_cur, m_idx) || out_last !== (m_idx == 11)))) begin
        n_err++;
        $display("FAIL rnd_cycle%0d: got valid=%0b level=%0d ovf=%0b data=%h last=%0b, need %0b %0d %0b %h %0b",
                 cyc, out_valid, level, ovf, out_data, out_last, m_busy, m_fifo.size(), m_ovf,
                 byte_of(m_cur, m_idx), (m_busy && m_idx == 11));
      end
      done = (cyc >= 400) && !m_busy;
    end
    n_vec++;
    if (!done || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_drain: got done=%0b valid=%0b, need 1 0", done, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_out_ser.md
MUL_OUT_SER -- requirements
Module: mul_out_ser

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 96-bit result words buffered (power of 2, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: product word present, driven by the multiplier's out_valid.
REQ-005 SHALL have port in_data, input, 96 bits: product word, driven by the multiplier's 96-bit out.
REQ-006 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the byte.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-008 SHALL have port out_data, output, 8 bits: current byte of the word being serialized.
REQ-009 SHALL have port out_last, output, 1 bit: the current byte is byte 11, the final byte of the word.
REQ-010 SHALL have port level, output, clog2(DEPTH)+1 bits: count of words in the FIFO, excluding the word in the shifter.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag marking that an input word was dropped.

Function
REQ-012 SHALL push in_data into the FIFO at a rising edge when in_valid=1 and either level<DEPTH or a FIFO pop occurs on the same edge.
REQ-013 SHALL drop an in_valid word that meets neither condition of REQ-012, set ovf=1, and leave ovf set until reset.
REQ-014 SHALL implement an FSM with states IDLE and SEND.
REQ-015 SHALL, in IDLE with level>0, pop the FIFO head into a 96-bit shift register, clear byte_cnt to 0, and move to SEND.
REQ-016 SHALL drive out_valid=1 in SEND and out_valid=0 in IDLE.
REQ-017 SHALL drive out_data = byte byte_cnt of the word, MSB-first: byte 0 = bits [95:88] and byte 11 = bits [7:0].
REQ-018 SHALL treat a byte as transferred only on an edge where out_valid=1 and out_ready=1; out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 SHALL increment byte_cnt on each transfer with byte_cnt<11.
REQ-020 SHALL, on transfer of byte 11, pop and load the next word with byte_cnt=0 and stay in SEND when level>0, giving no bubble; otherwise it SHALL return to IDLE.
REQ-021 SHALL drive out_last=1 exactly while in SEND with byte_cnt=11.
REQ-022 SHALL have latency of 2 clocks: in_valid at edge N into an empty IDLE block gives out_valid=1 after edge N+1.
REQ-023 SHALL emit words in arrival order and serialize every accepted word completely, as exactly 12 transfers.
REQ-024 SHALL update level by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-025 SHALL wrap the FIFO read and write pointers modulo DEPTH.

Reset
REQ-026 SHALL, on rst_n=0, immediately and asynchronously force out_valid=0, out_data=0, out_last=0, level=0, ovf=0, state=IDLE, byte_cnt=0, and both pointers to 0.
REQ-027 SHALL discard a partially sent word and all FIFO contents on reset asserted mid-operation, with no byte of them emitted after reset release.
REQ-028 SHALL accept a push on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL provide macro MUL_OUT_SER_LSB_FIRST_EN; when it is defined, byte order SHALL be LSB-first (byte 0 = bits [7:0], byte 11 = bits [95:88]); when it is undefined, byte order SHALL be MSB-first per REQ-017; all other behaviour SHALL be identical in both builds.

Verification
REQ-030 SHALL cover a single word: in_data=96'h0102030405060708090A0B0C, out_ready=1 held -> bytes 01..0C on 12 consecutive cycles, first byte 2 cycles after push, out_last with 0C, LSB_FIRST build gives 0C..01.
REQ-031 SHALL cover back-pressure: out_ready toggling 1,0,1,0 -> each byte held stable while out_ready=0; 12 transfers total; no byte repeated or skipped.
REQ-032 SHALL cover back-to-back words: 3 words pushed on consecutive cycles with out_ready=1 -> 36 bytes in order with no idle cycle between words; level peaks at 2.
REQ-033 SHALL cover overflow: DEPTH=4, out_ready=0, 6 words pushed -> 1 word in shifter, level=4, 6th word dropped, ovf=1 sticky; after release, exactly 5 words (60 bytes) out.
REQ-034 SHALL cover push while full with a pop: level=4 and byte 11 transferring while in_valid=1 -> word accepted, level stays 4, ovf stays 0.
REQ-035 SHALL cover reset mid-word: rst_n=0 after byte 5 -> outputs and level 0 at once; after release, a new word 96'hFF..FF emits 12 bytes of FF and no stale byte.
